// File: rtl/alu_pkg.sv
// Shared opcode and control-state types for the multi-cycle ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SHL  = 4'd5,
    ALU_SHR  = 4'd6,
    ALU_SAR  = 4'd7,
    ALU_MUL  = 4'd8,
    ALU_DIVU = 4'd9
  } alu_func_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
// hi/lo form a double-width working register: product accumulates in hi while the
// multiplier shifts out of lo; for division hi is the partial remainder and lo
// shifts the dividend out while quotient bits shift in.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
  logic             ge;

  // The last iteration's result is exposed combinationally so the top can
  // register it on the same edge that performs that iteration.
  assign done   = (cnt_q == CNT_W'(1));
  assign res_lo = lo_d;
  assign res_hi = hi_d;

  // Load operands on start, otherwise perform one multiply or divide step per cycle.
  always_comb begin
    cnt_d   = cnt_q;
    div_d   = div_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    addend  = lo_q[0] ? opnd_q : {WIDTH{1'b0}};
    sum_w   = {1'b0, hi_q} + {1'b0, addend};
    rem_sh  = {hi_q, lo_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, opnd_q};
    ge      = (rem_sh >= {1'b0, opnd_q});
    if (start) begin
      cnt_d  = CNT_W'(WIDTH);
      div_d  = is_div;
      opnd_d = is_div ? op_a : op_b;
      lo_d   = is_div ? op_b : op_a;
      hi_d   = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (div_q) begin
        hi_d = ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], ge};
      end else begin
        hi_d = sum_w[WIDTH:1];
        lo_d = {sum_w[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  // Iteration counter is control state and is cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Working registers carry data only; they are qualified by the counter.
  always_ff @(posedge clk) begin
    div_q  <= div_d;
    opnd_q <= opnd_d;
    hi_q   <= hi_d;
    lo_q   <= lo_d;
  end

endmodule

// File: rtl/alu_mc.sv
// Handshaked execute-stage ALU: single-cycle logic/arith/shift ops, iterative
// MUL/DIVU, registered result and C/Z/V/S flags with valid/ready on both sides.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_func,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_out_hi,
  output logic             c,
  output logic             z,
  output logic             v,
  output logic             s
);

  localparam int SH_W = $clog2(WIDTH);

  alu_state_t       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             c_q, c_d, z_q, z_d, v_q, v_d, s_q, s_d;
  logic             div_q, div_d;
  logic             azero_q, azero_d;

  logic             accept, consume, start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_lo, iter_hi;

  logic [SH_W-1:0]    shamt;
  logic [WIDTH:0]     sum_w, diff_w, shl_w, shr_w;
  logic signed [WIDTH:0] sar_w;
  logic [WIDTH-1:0]   sc_lo;
  logic               sc_c, sc_v;

  assign in_ready   = !rst && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign consume    = out_valid_q && out_ready;

  assign out_valid  = out_valid_q;
  assign alu_out    = lo_q;
  assign alu_out_hi = hi_q;
  assign c          = c_q;
  assign z          = z_q;
  assign v          = v_q;
  assign s          = s_q;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .is_div (alu_func == ALU_DIVU),
    .op_a   (alu_a),
    .op_b   (alu_b),
    .done   (iter_done),
    .res_lo (iter_lo),
    .res_hi (iter_hi)
  );

  // Single-cycle datapath; shifts carry one guard bit so the last bit out lands
  // in a fixed position and is naturally zero for a zero shift amount.
  always_comb begin
    shamt  = alu_a[SH_W-1:0];
    sum_w  = {1'b0, alu_b} + {1'b0, alu_a} + {{WIDTH{1'b0}}, cin};
    diff_w = {1'b0, alu_b} - {1'b0, alu_a} - {{WIDTH{1'b0}}, cin};
    shl_w  = {1'b0, alu_b} << shamt;
    shr_w  = {alu_b, 1'b0} >> shamt;
    sar_w  = $signed({alu_b, 1'b0}) >>> shamt;
    sc_lo  = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (alu_func)
      ALU_ADD: begin
        sc_lo = sum_w[WIDTH-1:0];
        sc_c  = sum_w[WIDTH];
        sc_v  = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum_w[WIDTH-1] != alu_b[WIDTH-1]);
      end
      ALU_SUB: begin
        sc_lo = diff_w[WIDTH-1:0];
        sc_c  = diff_w[WIDTH];
        sc_v  = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff_w[WIDTH-1] != alu_b[WIDTH-1]);
      end
      ALU_AND: sc_lo = alu_a & alu_b;
      ALU_OR:  sc_lo = alu_a | alu_b;
      ALU_XOR: sc_lo = alu_a ^ alu_b;
      ALU_SHL: begin
        sc_lo = shl_w[WIDTH-1:0];
        sc_c  = shl_w[WIDTH];
      end
      ALU_SHR: begin
        sc_lo = shr_w[WIDTH:1];
        sc_c  = shr_w[0];
      end
      ALU_SAR: begin
        sc_lo = sar_w[WIDTH:1];
        sc_c  = sar_w[0];
      end
      default: ;
    endcase
  end

  // Control FSM and output-register next values: accept, iterate, publish, consume.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    c_d         = c_q;
    z_d         = z_q;
    v_d         = v_q;
    s_d         = s_q;
    div_d       = div_q;
    azero_d     = azero_q;
    start       = 1'b0;
    if (consume) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          if ((alu_func == ALU_MUL) || (alu_func == ALU_DIVU)) begin
            start   = 1'b1;
            state_d = BUSY;
            div_d   = (alu_func == ALU_DIVU);
            azero_d = (alu_a == '0);
          end else begin
            out_valid_d = 1'b1;
            lo_d        = sc_lo;
            hi_d        = '0;
            c_d         = sc_c;
            v_d         = sc_v;
            z_d         = (sc_lo == '0);
            s_d         = sc_lo[WIDTH-1];
          end
        end
      end
      BUSY: begin
        if (iter_done) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          lo_d        = iter_lo;
          hi_d        = iter_hi;
          s_d         = iter_lo[WIDTH-1];
          if (div_q) begin
            c_d = 1'b0;
            v_d = azero_q;
            z_d = (iter_lo == '0);
          end else begin
            c_d = (iter_hi != '0);
            v_d = (iter_hi != '0);
            z_d = (iter_lo == '0) && (iter_hi == '0);
          end
        end
      end
    endcase
  end

  // State and visible outputs; reset wins over any accept or consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      v_q         <= 1'b0;
      s_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      c_q         <= c_d;
      z_q         <= z_d;
      v_q         <= v_d;
      s_q         <= s_d;
    end
  end

  // Operation kind and divide-by-zero marker captured at accept for flag generation.
  always_ff @(posedge clk) begin
    div_q   <= div_d;
    azero_q <= azero_d;
  end

endmodule
